// File: rtl/relay_code_pkg.sv
// Relay code table, fault codes and FSM encoding shared by the relay sense decoder.
package relay_code_pkg;

   localparam int unsigned MAX_COUNT = 13;
   localparam int unsigned NUM_CODES = MAX_COUNT + 1;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_BAD_CMD = 2'd1;
   localparam logic [1:0] FC_TIMEOUT = 2'd2;
   localparam logic [1:0] FC_DRIFT   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LOCKED,
      ST_FAULT
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] count;
   } decode_t;

   // Pattern layout: {pin3[2:0], pin11[2:0], pin12, pin13}
   localparam logic [7:0] RELAY_CODE [NUM_CODES] = '{
      8'b000_000_0_0,  // 0
      8'b001_000_0_0,  // 1
      8'b001_001_0_0,  // 2
      8'b001_100_0_0,  // 3
      8'b001_101_0_0,  // 4
      8'b010_000_0_0,  // 5
      8'b010_000_0_0,  // 6
      8'b010_001_0_0,  // 7
      8'b010_010_0_1,  // 8
      8'b100_000_0_0,  // 9
      8'b100_000_0_1,  // 10
      8'b100_000_0_1,  // 11
      8'b100_100_1_0,  // 12
      8'b100_010_1_0   // 13
   };

   // Expected pattern for a commanded count; illegal counts map to all-zero.
   function automatic logic [7:0] code_of(input logic [3:0] count);
      logic [7:0] code;
      code = '0;
      for (int unsigned i = 0; i < NUM_CODES; i++) begin
         if (4'(i) == count) code = RELAY_CODE[i];
      end
      return code;
   endfunction

   // Lowest count whose code matches; duplicates resolve to the lower index.
   function automatic decode_t decode(input logic [7:0] p);
      decode_t d;
      d = '0;
      for (int unsigned i = 0; i < NUM_CODES; i++) begin
         if (!d.valid && RELAY_CODE[i] == p) begin
            d.valid = 1'b1;
            d.count = 4'(i);
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/relay_debounce.sv
// Two-flop synchronizer and pattern debounce for the 8 relay sense bits.
module relay_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] raw,
   output logic [7:0] stable
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [7:0]    sync1;
   logic [7:0]    sync2;
   logic [7:0]    cand;
   logic [CW-1:0] cnt;

   // Bring the asynchronous sense lines into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // The reloading sample counts as the first of the run, so cnt holds the
   // number of further matching samples; stable loads on the run's last sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (sync2 != cand) begin
         cand <= sync2;
         cnt  <= '0;
         if (DEBOUNCE_CYCLES == 1) stable <= sync2;
      end else if (32'(cnt) + 32'd2 >= DEBOUNCE_CYCLES) begin
         stable <= cand;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/relay_sense_decoder.sv
// Decodes debounced relay sense lines into a lead count and supervises settling.
module relay_sense_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SETTLE_TIMEOUT  = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sense_pin3,
   input  logic [2:0] sense_pin11,
   input  logic       sense_pin12,
   input  logic       sense_pin13,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_count,
   output logic [3:0] count_out,
   output logic       count_valid,
   output logic       settled,
   output logic       busy,
   output logic       fault,
   output logic [1:0] fault_code
);

   import relay_code_pkg::*;

   localparam int unsigned TW = $clog2(SETTLE_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_TIMEOUT - 1);

   logic [7:0]    stable;
   logic [7:0]    expected;
   logic          match;
   decode_t       dec;
   state_t        state;
   state_t        state_nxt;
   logic [1:0]    fc_nxt;
   logic [3:0]    cmd_q;
   logic [TW-1:0] timer;

   relay_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    ({sense_pin3, sense_pin11, sense_pin12, sense_pin13}),
      .stable (stable)
   );

   // Compare against the command's own code so duplicate codes (6, 11) settle.
   always_comb begin
      expected = code_of(cmd_q);
      match    = (stable == expected);
      dec      = decode(stable);
   end

   // Registered decode of the stable pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_out   <= '0;
         count_valid <= 1'b0;
      end else begin
         count_out   <= dec.count;
         count_valid <= dec.valid;
      end
   end

   // Command latch and settle timer; the timer stops at its terminal value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= '0;
         timer <= '0;
      end else if (cmd_valid) begin
         cmd_q <= cmd_count;
         timer <= '0;
      end else if (state == ST_SETTLE && timer != TIMER_LAST) begin
         timer <= timer + TW'(1);
      end
   end

   // State and fault code registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         fault_code <= FC_NONE;
      end else begin
         state      <= state_nxt;
         fault_code <= fc_nxt;
      end
   end

   // Next-state logic; a new command overrides any same-cycle timeout or drift.
   always_comb begin
      state_nxt = state;
      fc_nxt    = fault_code;
      if (cmd_valid) begin
         if (cmd_count > 4'(MAX_COUNT)) begin
            state_nxt = ST_FAULT;
            fc_nxt    = FC_BAD_CMD;
         end else begin
            state_nxt = ST_SETTLE;
            fc_nxt    = FC_NONE;
         end
      end else begin
         case (state)
            ST_SETTLE: begin
               if (match) begin
                  state_nxt = ST_LOCKED;
               end else if (timer == TIMER_LAST) begin
                  state_nxt = ST_FAULT;
                  fc_nxt    = FC_TIMEOUT;
               end
            end
            ST_LOCKED: begin
               if (!match) begin
                  state_nxt = ST_FAULT;
                  fc_nxt    = FC_DRIFT;
               end
            end
            default: ;
         endcase
      end
   end

   // Moore status outputs.
   always_comb begin
      busy    = (state == ST_SETTLE);
      settled = (state == ST_LOCKED);
      fault   = (state == ST_FAULT);
   end

endmodule

// File: tb/tb_relay_sense_decoder.sv
// Directed testbench for relay_sense_decoder (DEBOUNCE_CYCLES=4, SETTLE_TIMEOUT=20).
module tb_relay_sense_decoder;

   localparam logic [7:0] P0  = 8'b000_000_0_0;
   localparam logic [7:0] P3  = 8'b001_100_0_0;
   localparam logic [7:0] P6  = 8'b010_000_0_0;
   localparam logic [7:0] P9  = 8'b100_000_0_0;

   logic       clk;
   logic       rst_n;
   logic [2:0] sense_pin3;
   logic [2:0] sense_pin11;
   logic       sense_pin12;
   logic       sense_pin13;
   logic       cmd_valid;
   logic [3:0] cmd_count;
   logic [3:0] count_out;
   logic       count_valid;
   logic       settled;
   logic       busy;
   logic       fault;
   logic [1:0] fault_code;

   int errors = 0;
   int checks = 0;

   relay_sense_decoder #(
      .DEBOUNCE_CYCLES(4),
      .SETTLE_TIMEOUT (20)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sense_pin3 (sense_pin3),
      .sense_pin11(sense_pin11),
      .sense_pin12(sense_pin12),
      .sense_pin13(sense_pin13),
      .cmd_valid  (cmd_valid),
      .cmd_count  (cmd_count),
      .count_out  (count_out),
      .count_valid(count_valid),
      .settled    (settled),
      .busy       (busy),
      .fault      (fault),
      .fault_code (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic set_sense(input logic [7:0] p);
      {sense_pin3, sense_pin11, sense_pin12, sense_pin13} = p;
   endtask

   // Pulse cmd_valid for one cycle; returns 1ns after the sampling edge.
   task automatic issue_cmd(input logic [3:0] c);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_count = c;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      rst_n = 1'b0;
      set_sense(P0);
      repeat (3) @(negedge clk);
      checks++;
      if ({count_out, count_valid, settled, busy, fault, fault_code} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: got cnt=%0d v=%0b s=%0b b=%0b f=%0b fc=%0d, required all 0",
                  count_out, count_valid, settled, busy, fault, fault_code);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      n = 0;
      while (count_valid !== 1'b1 && n < 7) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (count_valid !== 1'b1 || count_out !== 4'd0) begin
         errors++;
         $display("FAIL reset_decode: got v=%0b cnt=%0d after %0d cycles, required v=1 cnt=0",
                  count_valid, count_out, n);
      end
      checks++;
      if (settled !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got s=%0b f=%0b b=%0b, required 0 0 0", settled, fault, busy);
      end
   endtask

   task automatic test_cmd3;
      int bad;
      issue_cmd(4'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_sense(P3);
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || settled !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL cmd3_busy: got %0d samples not busy, required 0", bad);
      end
      @(negedge clk);
      checks++;
      if (settled !== 1'b1 || busy !== 1'b0 || count_out !== 4'd3 || fault !== 1'b0) begin
         errors++;
         $display("FAIL cmd3_lock: got s=%0b b=%0b cnt=%0d f=%0b, required s=1 b=0 cnt=3 f=0",
                  settled, busy, count_out, fault);
      end
   endtask

   task automatic test_duplicate;
      int n;
      issue_cmd(4'd6);
      set_sense(P6);
      n = 0;
      while (settled !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (settled !== 1'b1 || count_out !== 4'd5 || count_valid !== 1'b1) begin
         errors++;
         $display("FAIL dup6: got s=%0b cnt=%0d v=%0b, required s=1 cnt=5 v=1",
                  settled, count_out, count_valid);
      end
   endtask

   task automatic test_timeout;
      int bad;
      set_sense(P0);
      issue_cmd(4'd12);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || fault !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL timeout_early: got %0d samples out of SETTLE, required 0", bad);
      end
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fault: got f=%0b fc=%0d b=%0b, required f=1 fc=2 b=0",
                  fault, fault_code, busy);
      end
   endtask

   task automatic test_drift;
      int n;
      issue_cmd(4'd9);
      set_sense(P9);
      n = 0;
      while (settled !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (settled !== 1'b1 || count_out !== 4'd9) begin
         errors++;
         $display("FAIL drift_lock9: got s=%0b cnt=%0d, required s=1 cnt=9", settled, count_out);
      end
      @(posedge clk); #1; sense_pin13 = 1'b1;
      @(posedge clk); #1; sense_pin13 = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (settled !== 1'b1 || fault !== 1'b0 || count_out !== 4'd9) begin
         errors++;
         $display("FAIL glitch1: got s=%0b f=%0b cnt=%0d, required s=1 f=0 cnt=9",
                  settled, fault, count_out);
      end
      @(posedge clk); #1; sense_pin13 = 1'b1;
      repeat (3) @(posedge clk);
      #1; sense_pin13 = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (settled !== 1'b1 || fault !== 1'b0 || count_out !== 4'd9) begin
         errors++;
         $display("FAIL glitch3: got s=%0b f=%0b cnt=%0d, required s=1 f=0 cnt=9",
                  settled, fault, count_out);
      end
      @(posedge clk); #1; sense_pin13 = 1'b1;
      n = 0;
      while (fault !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'd3 || count_out !== 4'd10 || settled !== 1'b0) begin
         errors++;
         $display("FAIL drift: got f=%0b fc=%0d cnt=%0d s=%0b, required f=1 fc=3 cnt=10 s=0",
                  fault, fault_code, count_out, settled);
      end
   endtask

   task automatic test_bad_cmd;
      issue_cmd(4'd14);
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_cmd: got f=%0b fc=%0d b=%0b, required f=1 fc=1 b=0",
                  fault, fault_code, busy);
      end
   endtask

   task automatic test_cmd_vs_timeout;
      int bad;
      issue_cmd(4'd12);
      @(negedge clk);
      checks++;
      if (fault !== 1'b0 || fault_code !== 2'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL fault_exit: got f=%0b fc=%0d b=%0b, required f=0 fc=0 b=1",
                  fault, fault_code, busy);
      end
      repeat (18) @(posedge clk);
      issue_cmd(4'd12);
      @(negedge clk);
      checks++;
      if (fault !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL cmd_priority: got f=%0b b=%0b, required f=0 b=1", fault, busy);
      end
      bad = 0;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || fault !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL timer_restart: got %0d samples out of SETTLE, required 0", bad);
      end
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'd2) begin
         errors++;
         $display("FAIL restart_timeout: got f=%0b fc=%0d, required f=1 fc=2", fault, fault_code);
      end
   endtask

   task automatic test_reset_mid_settle;
      issue_cmd(4'd12);
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_busy: got b=%0b, required 1", busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({count_out, count_valid, settled, busy, fault, fault_code} !== 10'd0) begin
         errors++;
         $display("FAIL async_reset: got cnt=%0d v=%0b s=%0b b=%0b f=%0b fc=%0d, required all 0",
                  count_out, count_valid, settled, busy, fault, fault_code);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || fault !== 1'b0 || settled !== 1'b0 ||
          count_out !== 4'd10 || count_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset: got b=%0b f=%0b s=%0b cnt=%0d v=%0b, required 0 0 0 10 1",
                  busy, fault, settled, count_out, count_valid);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_count = '0;
      set_sense(P0);
      test_reset();
      test_cmd3();
      test_duplicate();
      test_timeout();
      test_drift();
      test_bad_cmd();
      test_cmd_vs_timeout();
      test_reset_mid_settle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
